// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the Data_Memory two-port arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_PORTS  = 2;

  // Sequencer states
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Port indices
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IMG = 1'b1;

  // Latched request payload driven onto the memory during ACCESS
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // True when every address bit above the implemented depth is zero
  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                         input int unsigned       aw);
    return (addr >> aw) == {DATA_W{1'b0}};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way pick: round-robin on ties, or fixed priority to port 0.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_owner_i,
  input  logic rr_i,
  output logic winner_o,
  output logic any_o
);

  // Winner selection; a tie in round-robin mode goes to the port that did not win last
  always_comb begin
    any_o    = req0_i | req1_i;
    winner_o = PORT_CPU;
    if (req0_i && req1_i) begin
      winner_o = rr_i ? ~last_owner_i : PORT_CPU;
    end else if (req1_i) begin
      winner_o = PORT_IMG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and single-access sequencer in front of Data_Memory.
// IDLE samples requests, ACCESS drives one memory cycle, the closing edge
// registers the response and always returns to IDLE.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter bit          RR     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_mwd,
  output logic        mem_mwr,
  output logic        mem_moe,
  input  logic [31:0] mem_mrd
);

  logic [0:0]                       state_q, state_d;
  logic                             owner_q, owner_d;
  logic                             last_owner_q, last_owner_d;
  mem_req_t                         req_q, req_d;
  mem_req_t                         cand;
  logic                             range_ok_q, range_ok_d;
  logic [NUM_PORTS-1:0]             rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]             err_q, err_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                             pick_winner;
  logic                             pick_any;
  logic                             access;

  rr_arbiter2 u_pick (
    .req0_i       (p0_req),
    .req1_i       (p1_req),
    .last_owner_i (last_owner_q),
    .rr_i         (RR),
    .winner_o     (pick_winner),
    .any_o        (pick_any)
  );

  // Payload of whichever port the arbiter picked this cycle
  always_comb begin
    cand = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
    if (pick_winner == PORT_IMG) begin
      cand = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
    end
  end

  // Next state: latch a winner in IDLE, build the response at the end of ACCESS
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    req_d        = req_q;
    range_ok_d   = range_ok_q;
    rvalid_d     = '0;
    err_d        = '0;
    rdata_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d    = pick_winner;
          req_d      = cand;
          range_ok_d = addr_in_range(cand.addr, ADDR_W);
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rvalid_d[owner_q] = 1'b1;
        err_d[owner_q]    = ~range_ok_q;
        rdata_d[owner_q]  = (range_ok_q && !req_q.we) ? mem_mrd : {DATA_W{1'b0}};
        last_owner_d      = owner_q;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; reset drops any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_CPU;
      last_owner_q <= PORT_IMG;
      req_q        <= '0;
      range_ok_q   <= 1'b0;
      rvalid_q     <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      req_q        <= req_d;
      range_ok_q   <= range_ok_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Memory strobes and grants decode only from registers; no req-to-memory path
  assign access  = (state_q == ST_ACCESS);
  assign p0_gnt  = access && (owner_q == PORT_CPU);
  assign p1_gnt  = access && (owner_q == PORT_IMG);
  assign mem_adr = req_q.addr;
  assign mem_mwd = req_q.wdata;
  assign mem_mwr = access && req_q.we && range_ok_q;
  assign mem_moe = access && !req_q.we && range_ok_q;

  assign p0_rvalid = rvalid_q[PORT_CPU];
  assign p1_rvalid = rvalid_q[PORT_IMG];
  assign p0_err    = err_q[PORT_CPU];
  assign p1_err    = err_q[PORT_IMG];
  assign p0_rdata  = rdata_q[PORT_CPU];
  assign p1_rdata  = rdata_q[PORT_IMG];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model and a behavioural stand-in for Data_Memory.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_adr, mem_mwd, mem_mrd;
  logic        mem_mwr, mem_moe;

  // Second instance in fixed-priority mode, used only for the priority test
  logic        f_req0, f_req1;
  logic        f_p0_gnt, f_p0_rvalid, f_p0_err, f_p1_gnt, f_p1_rvalid, f_p1_err;
  logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_adr, f_mem_mwd;
  logic        f_mem_mwr, f_mem_moe;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_adr(mem_adr), .mem_mwd(mem_mwd), .mem_mwr(mem_mwr), .mem_moe(mem_moe),
    .mem_mrd(mem_mrd)
  );

  dmem_arbiter #(.ADDR_W(AW), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(f_req0), .p0_we(1'b0), .p0_addr(32'd0), .p0_wdata(32'd0),
    .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata), .p0_err(f_p0_err),
    .p1_req(f_req1), .p1_we(1'b0), .p1_addr(32'd1), .p1_wdata(32'd0),
    .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata), .p1_err(f_p1_err),
    .mem_adr(f_mem_adr), .mem_mwd(f_mem_mwd), .mem_mwr(f_mem_mwr), .mem_moe(f_mem_moe),
    .mem_mrd(32'd0)
  );

  // Data_Memory stand-in: combinational read, write on the rising edge
  logic [31:0] bmem [DEPTH];
  assign mem_mrd = bmem[mem_adr[AW-1:0]];
  initial begin
    for (int i = 0; i < DEPTH; i++) bmem[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_mwr) bmem[mem_adr[AW-1:0]] = mem_mwd;
    end
  end

  // Transaction-level model: busy marks the access cycle, responses appear one cycle later
  logic [31:0] refmem [DEPTH];
  bit          m_busy, m_owner, m_last, m_we, m_ok;
  logic [31:0] m_adr, m_wd;
  bit   [1:0]  m_rv, m_er;
  logic [31:0] m_rd [2];

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_we = 0; m_ok = 0;
    m_adr = 32'd0; m_wd = 32'd0; m_rv = 2'b00; m_er = 2'b00;
    m_rd[0] = 32'd0; m_rd[1] = 32'd0;
  endtask

  task automatic model_step();
    bit w;
    if (rst) begin
      model_reset();
      return;
    end
    m_rv = 2'b00; m_er = 2'b00; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    if (m_busy) begin
      m_rv[m_owner] = 1'b1;
      m_er[m_owner] = !m_ok;
      m_rd[m_owner] = (m_ok && !m_we) ? refmem[m_adr % DEPTH] : 32'd0;
      if (m_ok && m_we) refmem[m_adr % DEPTH] = m_wd;
      m_last = m_owner;
      m_busy = 0;
    end else if (p0_req || p1_req) begin
      if (p0_req && p1_req) w = (m_last == 0) ? 1'b1 : 1'b0;
      else w = p1_req;
      m_owner = w;
      m_we    = w ? p1_we : p0_we;
      m_adr   = w ? p1_addr : p0_addr;
      m_wd    = w ? p1_wdata : p0_wdata;
      m_ok    = (m_adr < DEPTH);
      m_busy  = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) refmem[i] = 32'd0;
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
      chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
      chk("rst_p0_err", 32'(p0_err), 32'd0);
      chk("rst_p1_err", 32'(p1_err), 32'd0);
      chk("rst_p0_rdata", p0_rdata, 32'd0);
      chk("rst_p1_rdata", p1_rdata, 32'd0);
      chk("rst_mwr", 32'(mem_mwr), 32'd0);
      chk("rst_moe", 32'(mem_moe), 32'd0);
      chk("rst_adr", mem_adr, 32'd0);
      chk("rst_mwd", mem_mwd, 32'd0);
    end else begin
      chk("p0_gnt", 32'(p0_gnt), 32'(m_busy && !m_owner));
      chk("p1_gnt", 32'(p1_gnt), 32'(m_busy && m_owner));
      chk("mem_mwr", 32'(mem_mwr), 32'(m_busy && m_we && m_ok));
      chk("mem_moe", 32'(mem_moe), 32'(m_busy && !m_we && m_ok));
      if (m_busy) begin
        chk("mem_adr", mem_adr, m_adr);
        chk("mem_mwd", mem_mwd, m_wd);
      end
      chk("p0_rvalid", 32'(p0_rvalid), 32'(m_rv[0]));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(m_rv[1]));
      if (m_rv[0]) begin
        chk("p0_rdata", p0_rdata, m_rd[0]);
        chk("p0_err", 32'(p0_err), 32'(m_er[0]));
      end
      if (m_rv[1]) begin
        chk("p1_rdata", p1_rdata, m_rd[1]);
        chk("p1_err", 32'(p1_err), 32'(m_er[1]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    end
  endtask

  function automatic logic get_req(input int p);
    return (p == 0) ? p0_req : p1_req;
  endfunction
  function automatic logic get_gnt(input int p);
    return (p == 0) ? p0_gnt : p1_gnt;
  endfunction
  function automatic logic get_rv(input int p);
    return (p == 0) ? p0_rvalid : p1_rvalid;
  endfunction
  function automatic logic get_err(input int p);
    return (p == 0) ? p0_err : p1_err;
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? p0_rdata : p1_rdata;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete access; returns data/err and the grant and response latencies
  task automatic do_access(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic er, output int gl, output int rl);
    bit seen;
    rd = 32'd0; er = 1'b1; gl = 0; rl = 0;
    set_port(p, 1'b1, w, a, d);
    seen = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      tick();
      if (get_gnt(p)) begin
        seen = 1;
        gl = i;
      end
    end
    set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("gnt_wait", 32'(seen), 32'd1);
    if (!seen) return;
    seen = 0;
    for (int i = 1; i <= 4 && !seen; i++) begin
      tick();
      if (get_rv(p)) begin
        seen = 1;
        rl = i;
        rd = get_rdata(p);
        er = get_err(p);
      end
    end
    chk("rvalid_wait", 32'(seen), 32'd1);
  endtask

  task automatic rand_port(input int p, input logic granted);
    logic [31:0] a;
    if (get_req(p) && !granted) return;
    if ($urandom_range(0, 99) < 65) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
    end else begin
      set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er, g0, g1;
    int          gl, rl, fp0, fp1;
    int          seq[$];

    rst = 1'b1;
    f_req0 = 1'b0;
    f_req1 = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    chk("reset_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("reset_mem_adr", mem_adr, 32'd0);
    rst = 1'b0;

    // Write then read back address 5 on port 0
    set_port(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    tick();
    chk("t1_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("t1_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("t1_mwr", 32'(mem_mwr), 32'd1);
    chk("t1_adr", mem_adr, 32'd5);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("t1_wr_rvalid", 32'(p0_rvalid), 32'd1);
    chk("t1_wr_err", 32'(p0_err), 32'd0);
    do_access(0, 1'b0, 32'd5, 32'd0, rd, er, gl, rl);
    chk("t1_rd_gnt_lat", 32'(gl), 32'd1);
    chk("t1_rd_rv_lat", 32'(rl), 32'd1);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_err", 32'(er), 32'd0);

    // Same-cycle tie just after reset: port 0 first, port 1 two cycles later
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'd1, 32'h11);
    set_port(1, 1'b1, 1'b1, 32'd2, 32'h22);
    tick();
    chk("t2_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("t2_p1_gnt_n1", 32'(p1_gnt), 32'd0);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("t2_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("t2_p1_gnt_n2", 32'(p1_gnt), 32'd0);
    tick();
    chk("t2_p1_gnt_n3", 32'(p1_gnt), 32'd1);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("t2_p1_rvalid", 32'(p1_rvalid), 32'd1);
    do_access(0, 1'b0, 32'd1, 32'd0, rd, er, gl, rl);
    chk("t2_rd1", rd, 32'h11);
    do_access(1, 1'b0, 32'd2, 32'd0, rd, er, gl, rl);
    chk("t2_rd2", rd, 32'h22);

    // Out-of-range write from port 1 must not touch word 0
    do_access(0, 1'b1, 32'd0, 32'hA5A5A5A5, rd, er, gl, rl);
    set_port(1, 1'b1, 1'b1, 32'h40, 32'h55);
    tick();
    chk("t4_p1_gnt", 32'(p1_gnt), 32'd1);
    chk("t4_mwr", 32'(mem_mwr), 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("t4_rvalid", 32'(p1_rvalid), 32'd1);
    chk("t4_err", 32'(p1_err), 32'd1);
    chk("t4_rdata", p1_rdata, 32'd0);
    chk("t4_mem0", bmem[0], 32'hA5A5A5A5);

    // Request held through grant with a new address: back-to-back accesses
    do_access(0, 1'b1, 32'd3, 32'h33, rd, er, gl, rl);
    do_access(0, 1'b1, 32'd4, 32'h44, rd, er, gl, rl);
    set_port(0, 1'b1, 1'b0, 32'd3, 32'd0);
    tick();
    chk("t6_gnt_a", 32'(p0_gnt), 32'd1);
    p0_addr = 32'd4;
    tick();
    chk("t6_rv_a", 32'(p0_rvalid), 32'd1);
    chk("t6_rd_a", p0_rdata, 32'h33);
    tick();
    chk("t6_gnt_b", 32'(p0_gnt), 32'd1);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("t6_rv_b", 32'(p0_rvalid), 32'd1);
    chk("t6_rd_b", p0_rdata, 32'h44);

    // Reset in the middle of a write access
    set_port(0, 1'b1, 1'b1, 32'd7, 32'h77);
    tick();
    chk("t5_mwr_before", 32'(mem_mwr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_mwr_async", 32'(mem_mwr), 32'd0);
    chk("t5_gnt_async", 32'(p0_gnt), 32'd0);
    chk("t5_adr_async", mem_adr, 32'd0);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    chk("t5_mem7", bmem[7], 32'd0);
    tick();
    chk("t5_no_rvalid_a", 32'(p0_rvalid), 32'd0);
    tick();
    chk("t5_no_rvalid_b", 32'(p0_rvalid), 32'd0);

    // Both ports saturated: round-robin alternates, fixed priority starves port 1
    do_reset();
    set_port(0, 1'b1, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 32'd1, 32'd0);
    f_req0 = 1'b1;
    f_req1 = 1'b1;
    fp0 = 0;
    fp1 = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (p0_gnt) seq.push_back(0);
      if (p1_gnt) seq.push_back(1);
      fp0 += int'(f_p0_gnt);
      fp1 += int'(f_p1_gnt);
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    f_req0 = 1'b0;
    f_req1 = 1'b0;
    tick();
    tick();
    chk("t3_rr_count", 32'(seq.size()), 32'd8);
    for (int k = 0; k < seq.size(); k++) chk($sformatf("t3_rr_seq%0d", k), 32'(seq[k]), 32'(k % 2));
    chk("t3_fp_p0", 32'(fp0), 32'd8);
    chk("t3_fp_p1", 32'(fp1), 32'd0);

    // Randomized traffic from both requesters, checked by the per-cycle model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = p0_gnt;
      g1 = p1_gnt;
      @(posedge clk);
      #1;
      rand_port(0, g0);
      rand_port(1, g1);
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
